// File: rtl/bp_bimodal_pht_cp4.sv
// rtl/bp_bimodal_pht_cp4.sv - bimodal saturating-counter branch prediction table with stats
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   guess_valid/pc    fetch-side lookup request
//   guess_out_valid   registered lookup-valid, one cycle after guess_valid
//   guess_taken       registered prediction (counter MSB); holds when no lookup
//   check_valid/pc    execute-side resolved branch
//   check_taken       actual branch outcome
//   check_count       resolved branches seen (wraps)
//   mispredict_count  resolved branches whose pre-update prediction was wrong (wraps)

module bp_bimodal_pht_cp4 #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 5,
    parameter int CNT_WIDTH  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  guess_valid,
    input  logic [PC_WIDTH-1:0]   guess_pc,
    output logic                  guess_out_valid,
    output logic                  guess_taken,
    input  logic                  check_valid,
    input  logic [PC_WIDTH-1:0]   check_pc,
    input  logic                  check_taken,
    output logic [STAT_WIDTH-1:0] check_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int DEPTH = 1 << INDEX_BITS;

    // Weakly-not-taken: MSB clear, all lower bits set.
    localparam logic [CNT_WIDTH-1:0]  CNT_INIT = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MIN  = '0;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  table_q [DEPTH];
    logic [INDEX_BITS-1:0] gidx;
    logic [INDEX_BITS-1:0] cidx;
    logic [CNT_WIDTH-1:0]  check_cur;
    logic [CNT_WIDTH-1:0]  check_new;
    logic [CNT_WIDTH-1:0]  guess_cnt;
    logic                  check_miss;

    // pc[1:0] and the bits above the index do not select an entry; aliasing is intended.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{guess_pc[PC_WIDTH-1:INDEX_BITS+2], guess_pc[1:0],
                              check_pc[PC_WIDTH-1:INDEX_BITS+2], check_pc[1:0]};

    assign gidx = guess_pc[INDEX_BITS+1:2];
    assign cidx = check_pc[INDEX_BITS+1:2];

    assign check_cur  = table_q[cidx];
    assign check_miss = check_cur[CNT_WIDTH-1] != check_taken;

    always_comb begin
        check_new = check_cur;
        if (check_taken) begin
            if (check_cur != CNT_MAX) begin
                check_new = check_cur + CNT_ONE;
            end
        end else begin
            if (check_cur != CNT_MIN) begin
                check_new = check_cur - CNT_ONE;
            end
        end
    end

    // A same-cycle check to the same entry is forwarded so the guess sees the updated counter.
    always_comb begin
        guess_cnt = table_q[gidx];
        if (check_valid && (gidx == cidx)) begin
            guess_cnt = check_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= CNT_INIT;
            end
            guess_out_valid  <= 1'b0;
            guess_taken      <= 1'b0;
            check_count      <= '0;
            mispredict_count <= '0;
        end else begin
            guess_out_valid <= guess_valid;
            if (guess_valid) begin
                guess_taken <= guess_cnt[CNT_WIDTH-1];
            end
            if (check_valid) begin
                table_q[cidx] <= check_new;
                check_count   <= check_count + STAT_ONE;
                if (check_miss) begin
                    mispredict_count <= mispredict_count + STAT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_bimodal_pht_cp4.sv
// tb/tb_bp_bimodal_pht_cp4.sv - directed self-checking bench for bp_bimodal_pht_cp4

module tb_bp_bimodal_pht_cp4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        guess_valid;
    logic [31:0] guess_pc;
    logic        check_valid;
    logic [31:0] check_pc;
    logic        check_taken;

    logic        guess_out_valid;
    logic        guess_taken;
    logic [31:0] check_count;
    logic [31:0] mispredict_count;

    logic        s_guess_out_valid;
    logic        s_guess_taken;
    logic [2:0]  s_check_count;
    logic [2:0]  s_mispredict_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_bimodal_pht_cp4 dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .guess_valid      (guess_valid),
        .guess_pc         (guess_pc),
        .guess_out_valid  (guess_out_valid),
        .guess_taken      (guess_taken),
        .check_valid      (check_valid),
        .check_pc         (check_pc),
        .check_taken      (check_taken),
        .check_count      (check_count),
        .mispredict_count (mispredict_count)
    );

    // Narrow statistics instance so counter wrap is reachable in a few checks.
    bp_bimodal_pht_cp4 #(.STAT_WIDTH(3)) dut_small (
        .clk              (clk),
        .rst_n            (rst_n),
        .guess_valid      (guess_valid),
        .guess_pc         (guess_pc),
        .guess_out_valid  (s_guess_out_valid),
        .guess_taken      (s_guess_taken),
        .check_valid      (check_valid),
        .check_pc         (check_pc),
        .check_taken      (check_taken),
        .check_count      (s_check_count),
        .mispredict_count (s_mispredict_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs, then return inputs to idle and settle #1 past the edge.
    task automatic cyc(input logic gv, input logic [31:0] gpc,
                       input logic cv, input logic [31:0] cpc, input logic ct);
        guess_valid = gv;
        guess_pc    = gpc;
        check_valid = cv;
        check_pc    = cpc;
        check_taken = ct;
        @(posedge clk);
        #1;
        guess_valid = 1'b0;
        check_valid = 1'b0;
    endtask

    task automatic guess(input logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic check(input logic [31:0] pc, input logic t);
        cyc(1'b0, 32'h0, 1'b1, pc, t);
    endtask

    task automatic stats(input string tag, input int cc, input int mc);
        chk({tag, "_cc"}, check_count, 32'(cc));
        chk({tag, "_mc"}, mispredict_count, 32'(mc));
    endtask

    initial begin
        rst_n       = 1'b0;
        guess_valid = 1'b0;
        guess_pc    = '0;
        check_valid = 1'b0;
        check_pc    = '0;
        check_taken = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        chk("rst_gov", 32'(guess_out_valid), 32'd0);
        chk("rst_gt", 32'(guess_taken), 32'd0);
        stats("rst", 0, 0);

        guess(32'h40);
        chk("init_gov", 32'(guess_out_valid), 32'd1);
        chk("init_gt", 32'(guess_taken), 32'd0);
        stats("init", 0, 0);

        // 1 -> 2 (mispredict), 2 -> 3, 3 -> 3
        check(32'h40, 1'b1);
        chk("idle_gov", 32'(guess_out_valid), 32'd0);
        check(32'h40, 1'b1);
        check(32'h40, 1'b1);
        stats("inc", 3, 1);
        guess(32'h40);
        chk("sat_hi_gov", 32'(guess_out_valid), 32'd1);
        chk("sat_hi_gt", 32'(guess_taken), 32'd1);

        // 3 -> 2 (mis), 2 -> 1 (mis), 1 -> 0, 0 -> 0
        check(32'h40, 1'b0);
        check(32'h40, 1'b0);
        stats("dec2", 5, 3);
        check(32'h40, 1'b0);
        check(32'h40, 1'b0);
        stats("dec4", 7, 3);
        chk("hold_gt", 32'(guess_taken), 32'd1);
        guess(32'h40);
        chk("sat_lo_gt", 32'(guess_taken), 32'd0);

        // Same-cycle check+guess on index 0: old counter 1 would predict 0, updated 2 predicts 1.
        cyc(1'b1, 32'h80, 1'b1, 32'h80, 1'b1);
        chk("bypass_gt", 32'(guess_taken), 32'd1);
        stats("bypass", 8, 4);
        cyc(1'b1, 32'h84, 1'b1, 32'h80, 1'b1);
        chk("indep_gov", 32'(guess_out_valid), 32'd1);
        chk("indep_gt", 32'(guess_taken), 32'd0);
        stats("indep", 9, 4);

        // Aliasing: 0x04 and 0x84 share index 1 (1 -> 2 mis, 2 -> 3)
        check(32'h04, 1'b1);
        check(32'h04, 1'b1);
        guess(32'h84);
        chk("alias_gt", 32'(guess_taken), 32'd1);
        check(32'h00, 1'b1);
        check(32'h00, 1'b1);
        guess(32'h0);
        guess(32'h40);
        chk("idx16_gt", 32'(guess_taken), 32'd0);
        guess(32'hFFFF_FF83);
        chk("alias_hi_gt", 32'(guess_taken), 32'd1);
        stats("alias", 13, 5);
        chk("small_cc_mod", 32'(s_check_count), 32'd5);
        chk("small_mc", 32'(s_mispredict_count), 32'd5);

        // Mid-stream reset wins over same-cycle guess and check.
        rst_n = 1'b0;
        cyc(1'b1, 32'h84, 1'b1, 32'h84, 1'b1);
        rst_n = 1'b1;
        chk("mrst_gov", 32'(guess_out_valid), 32'd0);
        chk("mrst_gt", 32'(guess_taken), 32'd0);
        stats("mrst", 0, 0);
        guess(32'h84);
        chk("mrst_e1_gt", 32'(guess_taken), 32'd0);
        guess(32'h80);
        chk("mrst_e0_gt", 32'(guess_taken), 32'd0);
        guess(32'h40);
        chk("mrst_e16_gt", 32'(guess_taken), 32'd0);

        // Wrap on the 3-bit statistics instance: 7 checks, then the 8th wraps to 0.
        for (int i = 0; i < 7; i++) begin
            check(32'h08, 1'b1);
        end
        chk("small_cc7", 32'(s_check_count), 32'd7);
        chk("small_mc7", 32'(s_mispredict_count), 32'd1);
        check(32'h08, 1'b1);
        chk("small_wrap", 32'(s_check_count), 32'd0);
        stats("wrap_main", 8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
